// File: rtl/counter_updown_param_pkg.sv
// counter_updown_param_pkg: shared mode/direction constants and prescaler width helper
package counter_updown_param_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP = 1'b1;
  function automatic int presc_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: divides enabled cycles by PRESCALE into a single-cycle step tick
module counter_prescaler
  import counter_updown_param_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = presc_w(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  logic [PW-1:0] phase;
  assign tick = en && phase == LAST;
  // phase holds while en is low, so a paused count resumes mid-phase
  always_ff @(posedge clk or negedge reset)
    if (!reset) phase <= '0;
    else if (clr) phase <= '0;
    else if (en) phase <= tick ? '0 : phase + 1'b1;
endmodule

// File: rtl/counter_updown_param.sv
// counter_updown_param: prescaled up/down counter with runtime limit, wrap/saturate and terminal-count pulse
module counter_updown_param
  import counter_updown_param_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);
  logic tick, over, bound, step_tc;
  logic [WIDTH-1:0] step_val, load_clamp;
  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk(clk), .reset(reset), .en(en), .clr(load), .tick(tick)
  );
  assign at_max = count == max_val;
  assign at_min = count == '0;
  assign load_clamp = (load_val > max_val) ? max_val : load_val;
  // boundaries are tested before +/-1, so the arithmetic never overflows
  always_comb begin
    over = count > max_val;
    bound = (dir == DIR_UP) ? at_max : at_min;
    step_tc = !over && bound;
    step_val = over ? max_val
             : !bound ? ((dir == DIR_UP) ? count + 1'b1 : count - 1'b1)
             : (SATURATE == MODE_SAT) ? count
             : (dir == DIR_UP) ? '0 : max_val;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count <= '0;
      tc <= 1'b0;
    end else if (load) begin
      count <= load_clamp;
      tc <= 1'b0;
    end else if (tick) begin
      count <= step_val;
      tc <= step_tc;
    end else tc <= 1'b0;
endmodule

// File: tb/tb_counter_updown_param.sv
// tb_counter_updown_param: three parameter variants checked against an integer reference model
module tb_counter_updown_param;
  logic clk = 1'b0, reset = 1'b0, en = 1'b0, dir = 1'b0, load = 1'b0;
  logic [7:0] load_val = '0, max_val = '0;
  logic [7:0] cnt [3];
  logic tcs [3], amax [3], amin [3];
  int checks = 0, errors = 0;
  int m_cnt [3], m_ph [3];
  bit m_tc [3];
  int ps [3] = '{1, 1, 4};
  bit sat [3] = '{0, 1, 0};

  always #5 clk = ~clk;

  counter_updown_param #(.WIDTH(8), .PRESCALE(1), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .max_val(max_val), .count(cnt[0]), .tc(tcs[0]), .at_max(amax[0]), .at_min(amin[0]));
  counter_updown_param #(.WIDTH(8), .PRESCALE(1), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .max_val(max_val), .count(cnt[1]), .tc(tcs[1]), .at_max(amax[1]), .at_min(amin[1]));
  counter_updown_param #(.WIDTH(8), .PRESCALE(4), .SATURATE(0)) u_pre (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .max_val(max_val), .count(cnt[2]), .tc(tcs[2]), .at_max(amax[2]), .at_min(amin[2]));

  task automatic model(input int i);
    int c, mx;
    c = m_cnt[i];
    mx = int'(max_val);
    if (!reset) return;
    if (load) begin
      m_cnt[i] = (int'(load_val) > mx) ? mx : int'(load_val);
      m_ph[i] = 0;
      m_tc[i] = 0;
    end else if (!en) m_tc[i] = 0;
    else if (m_ph[i] < ps[i] - 1) begin
      m_ph[i]++;
      m_tc[i] = 0;
    end else begin
      m_ph[i] = 0;
      m_tc[i] = 0;
      if (c > mx) c = mx;
      else if (dir && c == mx) begin m_tc[i] = 1; if (!sat[i]) c = 0; end
      else if (!dir && c == 0) begin m_tc[i] = 1; if (!sat[i]) c = mx; end
      else c = dir ? c + 1 : c - 1;
      m_cnt[i] = c;
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model(i);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] !== 8'd0 || tcs[i] !== 1'b0 || amin[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset dut%0d: count=%0d tc=%b at_min=%b, expected 0 0 1", i, cnt[i], tcs[i], amin[i]);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_wrap_up();
    int n_tc = 0;
    max_val = 8'd255; en = 1'b1; dir = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      clk_step();
      if (tcs[0]) n_tc++;
      checks++;
      if (cnt[0] !== 8'(k % 256)) begin
        errors++;
        $display("FAIL wrap_up step %0d: count=%0d expected %0d", k, cnt[0], k % 256);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt[i] !== 8'(m_cnt[i]) || tcs[i] !== m_tc[i]) begin
          errors++;
          $display("FAIL wrap_up model dut%0d: count=%0d tc=%b expected %0d %b", i, cnt[i], tcs[i], m_cnt[i], m_tc[i]);
        end
      end
    end
    checks++;
    if (n_tc != 1) begin errors++; $display("FAIL wrap_up tc pulses: got %0d expected 1", n_tc); end
  endtask

  task automatic test_down_boundary();
    max_val = 8'd9; load = 1'b1; load_val = 8'd0; en = 1'b1;
    clk_step();
    load = 1'b0; dir = 1'b0;
    clk_step();
    checks++;
    if (cnt[0] !== 8'd9 || tcs[0] !== 1'b1 || cnt[1] !== 8'd0 || tcs[1] !== 1'b1) begin
      errors++;
      $display("FAIL down_boundary: wrap %0d/%b sat %0d/%b expected 9/1 0/1", cnt[0], tcs[0], cnt[1], tcs[1]);
    end
    repeat (3) begin
      clk_step();
      checks++;
      if (cnt[1] !== 8'd0 || tcs[1] !== 1'b1) begin
        errors++;
        $display("FAIL down_sat hold: count=%0d tc=%b expected 0 1", cnt[1], tcs[1]);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt[i] !== 8'(m_cnt[i]) || tcs[i] !== m_tc[i] || amax[i] !== (m_cnt[i] == 9)) begin
          errors++;
          $display("FAIL down model dut%0d: count=%0d tc=%b at_max=%b expected %0d %b", i, cnt[i], tcs[i], amax[i], m_cnt[i], m_tc[i]);
        end
      end
    end
  endtask

  task automatic test_prescaler();
    int n = 0;
    max_val = 8'd255; load = 1'b1; load_val = 8'd0; en = 1'b1; dir = 1'b1;
    clk_step();
    load = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      clk_step();
      checks++;
      if (cnt[2] !== 8'(k / 4)) begin
        errors++;
        $display("FAIL prescaler cycle %0d: count=%0d expected %0d", k, cnt[2], k / 4);
      end
    end
    while (cnt[2] != 8'd4 && n < 10) begin
      en = (n >= 2);
      clk_step();
      n++;
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL prescaler pause: step after %0d cycles expected 4", n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] !== 8'(m_cnt[i]) || tcs[i] !== m_tc[i]) begin
        errors++;
        $display("FAIL prescaler model dut%0d: count=%0d expected %0d", i, cnt[i], m_cnt[i]);
      end
    end
  endtask

  task automatic test_load();
    max_val = 8'd100; en = 1'b1; dir = 1'b1; load = 1'b1; load_val = 8'd200;
    clk_step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] !== 8'd100 || tcs[i] !== 1'b0 || amax[i] !== 1'b1) begin
        errors++;
        $display("FAIL load_clamp dut%0d: count=%0d tc=%b expected 100 0", i, cnt[i], tcs[i]);
      end
    end
    load_val = 8'd50;
    clk_step();
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      clk_step();
      checks++;
      if (cnt[2] !== ((k == 4) ? 8'd51 : 8'd50) || cnt[0] !== 8'(50 + k)) begin
        errors++;
        $display("FAIL load_restart cycle %0d: pre=%0d wrap=%0d expected %0d %0d", k, cnt[2], cnt[0], (k == 4) ? 51 : 50, 50 + k);
      end
    end
  endtask

  task automatic test_limit_change();
    max_val = 8'd255; load = 1'b1; load_val = 8'd80;
    clk_step();
    load = 1'b0; max_val = 8'd20; en = 1'b1; dir = 1'b1;
    clk_step();
    checks++;
    if (cnt[0] !== 8'd20 || tcs[0] !== 1'b0) begin
      errors++;
      $display("FAIL limit_clamp: count=%0d tc=%b expected 20 0", cnt[0], tcs[0]);
    end
    clk_step();
    checks++;
    if (cnt[0] !== 8'd0 || tcs[0] !== 1'b1) begin
      errors++;
      $display("FAIL limit_wrap: count=%0d tc=%b expected 0 1", cnt[0], tcs[0]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] !== 8'(m_cnt[i]) || tcs[i] !== m_tc[i]) begin
        errors++;
        $display("FAIL limit model dut%0d: count=%0d tc=%b expected %0d %b", i, cnt[i], tcs[i], m_cnt[i], m_tc[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    max_val = 8'd255; load = 1'b1; load_val = 8'd30;
    clk_step();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    repeat (7) clk_step();
    checks++;
    if (cnt[0] !== 8'd37) begin errors++; $display("FAIL async_pre: count=%0d expected 37", cnt[0]); end
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 0;
      checks++;
      if (cnt[i] !== 8'd0 || tcs[i] !== 1'b0 || amin[i] !== 1'b1) begin
        errors++;
        $display("FAIL async_reset dut%0d: count=%0d tc=%b expected 0 0", i, cnt[i], tcs[i]);
      end
    end
    clk_step();
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      clk_step();
      checks++;
      if (cnt[2] !== ((k == 4) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL async_resume cycle %0d: count=%0d expected %0d", k, cnt[2], (k == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      en = $urandom_range(0, 3) != 0;
      dir = $urandom_range(0, 1) == 1;
      load = $urandom_range(0, 15) == 0;
      load_val = 8'($urandom);
      if ($urandom_range(0, 19) == 0)
        case ($urandom_range(0, 3))
          0: max_val = 8'd0;
          1: max_val = 8'($urandom_range(1, 5));
          2: max_val = 8'd255;
          default: max_val = 8'($urandom);
        endcase
      clk_step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt[i] !== 8'(m_cnt[i]) || tcs[i] !== m_tc[i] ||
            amax[i] !== (m_cnt[i] == int'(max_val)) || amin[i] !== (m_cnt[i] == 0)) begin
          errors++;
          $display("FAIL random %0d dut%0d: count=%0d tc=%b max=%b min=%b expected %0d %b", k, i, cnt[i], tcs[i], amax[i], amin[i], m_cnt[i], m_tc[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_down_boundary();
    test_prescaler();
    test_load();
    test_limit_change();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
